// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the dual-port round-robin RAM arbiter.
package ram_arb_pkg;
  localparam int MAX_NUM_REQ = 4;
  localparam int PTR_W       = 2;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] onehot);
    logic [PTR_W-1:0] idx;
    idx = {PTR_W{1'b0}};
    for (int i = 0; i < MAX_NUM_REQ; i++) begin
      idx = idx | (onehot[i] ? PTR_W'(i) : {PTR_W{1'b0}});
    end
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: search starts at ptr_i and wraps.
module rr_arbiter import ram_arb_pkg::*; #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   next_ptr_o
);

  logic [NUM_REQ-1:0]     beaten_s;
  logic [MAX_NUM_REQ-1:0] grant_wide_s;
  logic [PTR_W-1:0]       grant_idx_s;

  // Distance of requester i past the pointer; smaller distance wins.
  function automatic int rank(input int i, input logic [PTR_W-1:0] ptr);
    int r;
    r = i - int'(ptr);
    return (r < 0) ? r + NUM_REQ : r;
  endfunction

  // Grant each valid requester that no closer valid requester beats.
  always_comb begin
    beaten_s = {NUM_REQ{1'b0}};
    grant_o  = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        beaten_s[i] = beaten_s[i] | (valid_i[j] && (rank(j, ptr_i) < rank(i, ptr_i)));
      end
      grant_o[i] = valid_i[i] & ~beaten_s[i];
    end
  end

  assign grant_wide_s = MAX_NUM_REQ'(grant_o);
  assign grant_idx_s  = onehot_to_idx(grant_wide_s);

  // Pointer moves just past the winner, holds when nobody is granted.
  always_comb begin
    if (!(|grant_o)) begin
      next_ptr_o = ptr_i;
    end else if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
      next_ptr_o = {PTR_W{1'b0}};
    end else begin
      next_ptr_o = grant_idx_s + PTR_W'(1);
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Multiplexes NUM_REQ write and NUM_REQ read requesters onto one RAM with
// independent round-robin arbitration and a one-cycle read response tag.
module ram_rr_arbiter import ram_arb_pkg::*; #(
  parameter int   NUM_REQ         = 2,
  parameter int   ADDR_WIDTH      = 9,
  parameter int   DATA_WIDTH      = 32,
  parameter int   MASK_WIDTH      = 1,
  parameter logic COLLISION_STALL = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_req_valid,
  output logic [NUM_REQ-1:0]            wr_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_req_data,
  input  logic [NUM_REQ*MASK_WIDTH-1:0] wr_req_mask,
  input  logic [NUM_REQ-1:0]            rd_req_valid,
  output logic [NUM_REQ-1:0]            rd_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_req_addr,
  output logic [NUM_REQ-1:0]            rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]         rd_rsp_data,
  output logic                          ram_wr_en,
  output logic [MASK_WIDTH-1:0]         ram_wr_mask,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic                          ram_rd_en,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_REQ-1:0]    rsp_tag_q, rsp_tag_d;
  logic [NUM_REQ-1:0]    wr_grant_s, rd_grant_s, rd_elig_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [MASK_WIDTH-1:0] wr_mask_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .valid_i    (wr_req_valid),
    .ptr_i      (wr_ptr_q),
    .grant_o    (wr_grant_s),
    .next_ptr_o (wr_ptr_d)
  );

  // Granted write slice, all-zero when no write wins.
  always_comb begin
    wr_addr_s = {ADDR_WIDTH{1'b0}};
    wr_data_s = {DATA_WIDTH{1'b0}};
    wr_mask_s = {MASK_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      wr_addr_s = wr_addr_s | (wr_grant_s[i] ? wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}});
      wr_data_s = wr_data_s | (wr_grant_s[i] ? wr_req_data[i*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}});
      wr_mask_s = wr_mask_s | (wr_grant_s[i] ? wr_req_mask[i*MASK_WIDTH +: MASK_WIDTH] : {MASK_WIDTH{1'b0}});
    end
  end

  // A read aimed at this cycle's write address sits out, so it never sees stale data.
  always_comb begin
    rd_elig_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_elig_s[i] = rd_req_valid[i] &
                     ~(COLLISION_STALL & (|wr_grant_s) &
                       (rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_s));
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .valid_i    (rd_elig_s),
    .ptr_i      (rd_ptr_q),
    .grant_o    (rd_grant_s),
    .next_ptr_o (rd_ptr_d)
  );

  // Granted read address, zero when idle.
  always_comb begin
    rd_addr_s = {ADDR_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_addr_s = rd_addr_s | (rd_grant_s[i] ? rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : {ADDR_WIDTH{1'b0}});
    end
  end

  assign rsp_tag_d = rd_grant_s;

  // Pointers and response tag; the tag lines up with the RAM's read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      rsp_tag_q <= {NUM_REQ{1'b0}};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rsp_tag_q <= rsp_tag_d;
    end
  end

  assign wr_req_ready = wr_grant_s;
  assign rd_req_ready = rd_grant_s;
  assign ram_wr_en    = |wr_grant_s;
  assign ram_wr_addr  = wr_addr_s;
  assign ram_wr_data  = wr_data_s;
  assign ram_wr_mask  = wr_mask_s;
  assign ram_rd_en    = |rd_grant_s;
  assign ram_rd_addr  = rd_addr_s;
  assign rd_rsp_valid = rsp_tag_q;
  assign rd_rsp_data  = (|rsp_tag_q) ? ram_rd_data : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: three configurations checked against a queue-free
// round-robin model every cycle, plus directed scenarios with literal values.
module tb_ram_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: N=2 stall on; instance 1: N=2 stall off; instance 2: N=4 stall on.
  logic [3:0]  wv [3];
  logic [3:0]  rv [3];
  logic [8:0]  wa [3][4];
  logic [8:0]  ra [3][4];
  logic [31:0] wd [3][4];
  logic        wm [3][4];

  logic [3:0]  o_wrdy [3];
  logic [3:0]  o_rrdy [3];
  logic [3:0]  o_rspv [3];
  logic        o_wen  [3];
  logic        o_ren  [3];
  logic        o_wmsk [3];
  logic [8:0]  o_wadr [3];
  logic [8:0]  o_radr [3];
  logic [31:0] o_wdat [3];
  logic [31:0] o_rspd [3];

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  function automatic int nreq(input int g);
    return (g == 2) ? 4 : 2;
  endfunction

  function automatic bit stall(input int g);
    return (g != 1);
  endfunction

  function automatic logic [31:0] ramf(input logic [8:0] a);
    return (a == 9'h005) ? 32'hDEADBEEF : ({a, 23'h000000} ^ {23'h000000, a} ^ 32'h5A5A0000);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int   N  = (g == 2) ? 4 : 2;
    localparam logic CS = (g == 1) ? 1'b0 : 1'b1;
    logic [N*9-1:0]  wa_p, ra_p;
    logic [N*32-1:0] wd_p;
    logic [N-1:0]    wm_p, wrdy_l, rrdy_l, rspv_l;
    logic            wen_l, ren_l, wmsk_l;
    logic [8:0]      wadr_l, radr_l;
    logic [31:0]     wdat_l, rspd_l, rdata_l;

    for (genvar j = 0; j < N; j++) begin : g_pack
      assign wa_p[j*9 +: 9]   = wa[g][j];
      assign ra_p[j*9 +: 9]   = ra[g][j];
      assign wd_p[j*32 +: 32] = wd[g][j];
      assign wm_p[j]          = wm[g][j];
    end

    ram_rr_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(9), .DATA_WIDTH(32), .MASK_WIDTH(1), .COLLISION_STALL(CS)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wr_req_valid(wv[g][N-1:0]), .wr_req_ready(wrdy_l),
      .wr_req_addr(wa_p), .wr_req_data(wd_p), .wr_req_mask(wm_p),
      .rd_req_valid(rv[g][N-1:0]), .rd_req_ready(rrdy_l), .rd_req_addr(ra_p),
      .rd_rsp_valid(rspv_l), .rd_rsp_data(rspd_l),
      .ram_wr_en(wen_l), .ram_wr_mask(wmsk_l), .ram_wr_addr(wadr_l), .ram_wr_data(wdat_l),
      .ram_rd_en(ren_l), .ram_rd_addr(radr_l), .ram_rd_data(rdata_l)
    );

    // RAM stand-in: one-cycle latency, garbage when not read.
    always @(posedge clk) rdata_l <= ren_l ? ramf(radr_l) : $urandom;

    assign o_wrdy[g] = 4'(wrdy_l);
    assign o_rrdy[g] = 4'(rrdy_l);
    assign o_rspv[g] = 4'(rspv_l);
    assign o_wen[g]  = wen_l;
    assign o_ren[g]  = ren_l;
    assign o_wmsk[g] = wmsk_l;
    assign o_wadr[g] = wadr_l;
    assign o_radr[g] = radr_l;
    assign o_wdat[g] = wdat_l;
    assign o_rspd[g] = rspd_l;
  end

  // Reference model state.
  int         wptr [3];
  int         rptr [3];
  logic [3:0] etag [3];
  logic [8:0] erad [3];

  function automatic int pick(input logic [3:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_comb(input int g, output int wg, output int rg, output logic [8:0] wae);
    logic [3:0] elig;
    int n;
    n    = nreq(g);
    wg   = pick(wv[g], wptr[g], n);
    wae  = (wg >= 0) ? wa[g][wg] : 9'h000;
    elig = 4'b0000;
    for (int i = 0; i < n; i++)
      elig[i] = rv[g][i] && !(stall(g) && wg >= 0 && ra[g][i] == wae);
    rg = pick(elig, rptr[g], n);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 3; g++) begin
        wptr[g] <= 0; rptr[g] <= 0; etag[g] <= 4'b0000; erad[g] <= 9'h000;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        int wg, rg;
        logic [8:0] wae;
        model_comb(g, wg, rg, wae);
        if (wg >= 0) wptr[g] <= (wg + 1) % nreq(g);
        if (rg >= 0) rptr[g] <= (rg + 1) % nreq(g);
        etag[g] <= (rg >= 0) ? (4'b0001 << rg) : 4'b0000;
        erad[g] <= (rg >= 0) ? ra[g][rg] : 9'h000;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int g = 0; g < 3; g++) begin
        int wg, rg;
        logic [8:0] wae;
        model_comb(g, wg, rg, wae);
        chk($sformatf("wr_ready[%0d]", g), 64'(o_wrdy[g]), (wg >= 0) ? 64'(4'b0001 << wg) : 64'd0);
        chk($sformatf("ram_wr_en[%0d]", g), 64'(o_wen[g]), 64'(wg >= 0));
        chk($sformatf("ram_wr_addr[%0d]", g), 64'(o_wadr[g]), 64'(wae));
        chk($sformatf("ram_wr_data[%0d]", g), 64'(o_wdat[g]), (wg >= 0) ? 64'(wd[g][wg]) : 64'd0);
        chk($sformatf("ram_wr_mask[%0d]", g), 64'(o_wmsk[g]), (wg >= 0) ? 64'(wm[g][wg]) : 64'd0);
        chk($sformatf("rd_ready[%0d]", g), 64'(o_rrdy[g]), (rg >= 0) ? 64'(4'b0001 << rg) : 64'd0);
        chk($sformatf("ram_rd_en[%0d]", g), 64'(o_ren[g]), 64'(rg >= 0));
        chk($sformatf("ram_rd_addr[%0d]", g), 64'(o_radr[g]), (rg >= 0) ? 64'(ra[g][rg]) : 64'd0);
        chk($sformatf("rsp_valid[%0d]", g), 64'(o_rspv[g]), 64'(etag[g]));
        chk($sformatf("rsp_data[%0d]", g), 64'(o_rspd[g]), (etag[g] != 4'b0000) ? 64'(ramf(erad[g])) : 64'd0);
      end
    end
  end

  task automatic clear_inputs();
    for (int g = 0; g < 3; g++) begin
      wv[g] = 4'b0000; rv[g] = 4'b0000;
      for (int j = 0; j < 4; j++) begin
        wa[g][j] = 9'h000; ra[g][j] = 9'h000; wd[g][j] = 32'h0; wm[g][j] = 1'b0;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int cw [4];
  int cr [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    for (int g = 0; g < 3; g++) chk($sformatf("reset_rsp_valid[%0d]", g), 64'(o_rspv[g]), 64'd0);
    rst_n = 1'b1;

    // Collision scenario on both N=2 instances (stall on / off).
    for (int g = 0; g < 2; g++) begin
      wv[g] = 4'b0010; wa[g][1] = 9'h010; wd[g][1] = 32'h1234_5678; wm[g][1] = 1'b1;
      rv[g] = 4'b0011; ra[g][0] = 9'h010; ra[g][1] = 9'h020;
    end
    #2;
    chk("cs1_wr_grant", 64'(o_wrdy[0]), 64'h2);
    chk("cs1_rd_grant", 64'(o_rrdy[0]), 64'h2);
    chk("cs1_rd_addr", 64'(o_radr[0]), 64'h020);
    chk("cs0_rd_grant", 64'(o_rrdy[1]), 64'h1);
    chk("cs0_rd_addr", 64'(o_radr[1]), 64'h010);
    next_cycle();
    for (int g = 0; g < 2; g++) begin
      wv[g] = 4'b0000; rv[g] = 4'b0001;
    end
    #2;
    chk("cs1_rd_next", 64'(o_rrdy[0]), 64'h1);
    chk("cs1_rsp_valid", 64'(o_rspv[0]), 64'h2);
    chk("cs1_rsp_data", 64'(o_rspd[0]), 64'(ramf(9'h020)));
    next_cycle();
    clear_inputs();

    // Single read with known RAM content.
    rv[0] = 4'b0001; ra[0][0] = 9'h005;
    #2;
    chk("rd5_grant", 64'(o_rrdy[0]), 64'h1);
    next_cycle();
    clear_inputs();
    #2;
    chk("rd5_rsp_valid", 64'(o_rspv[0]), 64'h1);
    chk("rd5_rsp_data", 64'(o_rspd[0]), 64'hDEADBEEF);
    next_cycle();

    // Two writers held for four cycles alternate.
    wv[0] = 4'b0011; wa[0][0] = 9'h0A1; wa[0][1] = 9'h0B2;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("alt_wr_grant", 64'(o_wrdy[0]), (c % 2 == 0) ? 64'h1 : 64'h2);
      chk("alt_wr_addr", 64'(o_wadr[0]), (c % 2 == 0) ? 64'h0A1 : 64'h0B2);
      next_cycle();
    end
    clear_inputs();

    // Four requesters, all valid for eight cycles.
    for (int i = 0; i < 4; i++) begin
      cw[i] = 0; cr[i] = 0;
      wa[2][i] = 9'h100 + 9'(i); ra[2][i] = 9'(i);
    end
    wv[2] = 4'b1111; rv[2] = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #2;
      chk("n4_wr_order", 64'(o_wrdy[2]), 64'(4'b0001 << (c % 4)));
      chk("n4_rd_order", 64'(o_rrdy[2]), 64'(4'b0001 << (c % 4)));
      for (int i = 0; i < 4; i++) begin
        cw[i] += int'(o_wrdy[2][i]);
        cr[i] += int'(o_rrdy[2][i]);
      end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("n4_wr_count[%0d]", i), 64'(cw[i]), 64'd2);
      chk($sformatf("n4_rd_count[%0d]", i), 64'(cr[i]), 64'd2);
    end
    clear_inputs();

    // Reset arrives while a read is granted: no response may escape.
    rv[0] = 4'b0001; ra[0][0] = 9'h033;
    #2;
    chk("rst_rd_grant", 64'(o_rrdy[0]), 64'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_rsp", 64'(o_rspv[0]), 64'd0);
    next_cycle();
    clear_inputs();
    #1;
    chk("rst_rsp_suppressed", 64'(o_rspv[0]), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    wv[0] = 4'b0011; wa[0][0] = 9'h040; wa[0][1] = 9'h041;
    rv[0] = 4'b0011; ra[0][0] = 9'h050; ra[0][1] = 9'h051;
    #2;
    chk("post_rst_wr_grant", 64'(o_wrdy[0]), 64'h1);
    chk("post_rst_rd_grant", 64'(o_rrdy[0]), 64'h1);
    chk("post_rst_rsp_valid", 64'(o_rspv[0]), 64'd0);
    next_cycle();

    // Randomized traffic with a narrow address range to force collisions.
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < 3; g++) begin
        wv[g] = 4'($urandom) & 4'((1 << nreq(g)) - 1);
        rv[g] = 4'($urandom) & 4'((1 << nreq(g)) - 1);
        for (int j = 0; j < 4; j++) begin
          wa[g][j] = 9'($urandom_range(0, 3));
          ra[g][j] = 9'($urandom_range(0, 3));
          wd[g][j] = $urandom;
          wm[g][j] = 1'($urandom);
        end
      end
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
